// File: rtl/debug_trace_pkg.sv
// Shared types and constants for the debug trace UART transmitter.
package debug_trace_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic [7:0] ASCII_0  = 8'h30;
  localparam logic [7:0] ASCII_A  = 8'h41;
  localparam logic [7:0] ASCII_LF = 8'h0A;

  // 16 hex digits followed by a line feed
  localparam int CHARS_PER_WORD = 17;

  // Uppercase ASCII hex digit for one nibble
  function automatic logic [7:0] hex_ascii(input logic [3:0] nib);
    if (nib < 4'd10) return ASCII_0 + {4'd0, nib};
    else             return ASCII_A + {4'd0, nib} - 8'd10;
  endfunction

endpackage

// File: rtl/debug_trace_uart_tx_fifo.sv
// Synchronous FIFO for captured trace words. A push while full is only
// accepted when a pop happens on the same edge.
module trace_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      level
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      level <= level + 1'b1;
      else if (!do_push && do_pop) level <= level - 1'b1;
    end
  end

  // Storage array; contents are don't-care while unoccupied
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/debug_trace_uart_tx.sv
// Captures changing CPU debug words and streams them as 16 hex digits + LF
// on an 8N1 UART line.
//
// state | meaning
// IDLE  | waiting for a queued word; pops it when available
// LOAD  | pick the next character (hex digit or LF) into the shift register
// START | start bit (low) for one bit time
// DATA  | eight data bits, LSB first
// STOP  | stop bit (high); then next character or back to IDLE
module debug_trace_uart_tx
  import debug_trace_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4,
  parameter int DATA_W       = 64,
  localparam int LVL_W = $clog2(FIFO_DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] debug_in,
  input  logic              capture_en,
  output logic              tx,
  output logic              busy,
  output logic              overflow,
  output logic [LVL_W-1:0]  fifo_level
);

  localparam int BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BAUD_W-1:0] BAUD_TC   = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [4:0]        LAST_CHAR = 5'(CHARS_PER_WORD - 1);

  tx_state_t         state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [4:0]        char_idx, char_n;
  logic [DATA_W-1:0] word, word_n;
  logic [7:0]        shreg, sh_n;
  logic              busy_n;
  logic              tx_n;
  logic              pop;
  logic [DATA_W-1:0] last_value;
  logic              push_req;
  logic [DATA_W-1:0] fifo_dout;
  logic              fifo_full;
  logic              fifo_empty;

  assign push_req = capture_en && (debug_in != last_value);

  trace_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push_req),
    .pop   (pop),
    .din   (debug_in),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Change detection and sticky drop flag
  always_ff @(posedge clk) begin
    if (rst) begin
      last_value <= '0;
      overflow   <= 1'b0;
    end else begin
      if (capture_en) last_value <= debug_in;
      if (push_req && fifo_full && !pop) overflow <= 1'b1;
    end
  end

  // Transmitter state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      word     <= '0;
      shreg    <= '0;
      busy     <= 1'b0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      char_idx <= char_n;
      word     <= word_n;
      shreg    <= sh_n;
      busy     <= busy_n;
      tx       <= tx_n;
    end
  end

  // Next-state and line level; tx is registered so the line lags state by one cycle
  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_idx;
    char_n  = char_idx;
    word_n  = word;
    sh_n    = shreg;
    busy_n  = busy;
    tx_n    = 1'b1;
    pop     = 1'b0;
    unique case (state)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          word_n  = fifo_dout;
          char_n  = '0;
          busy_n  = 1'b1;
          state_n = LOAD;
        end
      end
      LOAD: begin
        // word is shifted left each character so the next digit is always on top
        sh_n    = (char_idx == LAST_CHAR) ? ASCII_LF : hex_ascii(word[DATA_W-1 -: 4]);
        word_n  = {word[DATA_W-5:0], 4'h0};
        baud_n  = BAUD_TC;
        state_n = START;
      end
      START: begin
        tx_n = 1'b0;
        if (baud_cnt == '0) begin
          baud_n  = BAUD_TC;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      DATA: begin
        tx_n = shreg[0];
        if (baud_cnt == '0) begin
          baud_n = BAUD_TC;
          sh_n   = {1'b0, shreg[7:1]};
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 1'b1;
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      STOP: begin
        tx_n = 1'b1;
        if (baud_cnt == '0) begin
          if (char_idx == LAST_CHAR) begin
            busy_n  = 1'b0;
            state_n = IDLE;
          end else begin
            char_n  = char_idx + 1'b1;
            state_n = LOAD;
          end
        end else begin
          baud_n = baud_cnt - 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
